icon_row_show: RTL and testbench
================================

Name: icon_row_show

Overview:
- Parametrised HUD icon-row renderer for the VGA overlay path; successor to the single-row life indicator.
- Draws up to MAX_COUNT identical sprites left-to-right from a fixed origin. Displayed count is sampled once per frame, so the row never tears mid-frame.
- Icons removed by a count decrease blink for a set number of frames before disappearing.
- Output is a pipelined 24-bit pixel plus a valid flag, feeding the existing overlay priority mux.

Parameters:
- ICON_W_LOG2, 4: icon width = 2**ICON_W_LOG2 pixels.
- ICON_H, 16: icon height in rows, 1..2**ICON_W_LOG2.
- SLOT_SHIFT, 4: slot pitch = 2**SLOT_SHIFT pixels; must be >= ICON_W_LOG2. Columns between icon width and pitch are gap.
- MAX_COUNT, 8: maximum icons drawn, 1..15.
- ORIGIN_X, 0: left edge of slot 0.
- ORIGIN_Y, 460: top row of the icon row.
- FLIP_Y, 1: 1 = ROM row 0 is the icon bottom row.
- BLINK_PERIOD, 8: frames per blink phase.
- BLINK_TOGGLES, 6: phase toggles before removed icons vanish.

Ports:
- clk, in, 1: pixel clock.
- rst_n, in, 1: asynchronous active-low reset.
- frame_start, in, 1: one-cycle pulse at the start of each frame (vertical blank).
- current_pixel_x, in, 10: scan x.
- current_pixel_y, in, 10: scan y.
- icon_count, in, 4: requested count; values above MAX_COUNT clamp to MAX_COUNT.
- icon_pixel, out, 24: RGB888 pixel.
- icon_pixel_valid, out, 1: pixel is opaque icon content.
- blink_active, out, 1: a blink sequence is in progress.

Behaviour:
Reset:
- icon_pixel = 0, icon_pixel_valid = 0, blink_active = 0.
- shown_count = 0, state = IDLE, all pipeline valids = 0.

Count FSM (evaluated only on frame_start; between pulses all state holds):
- c = min(icon_count, MAX_COUNT).
- IDLE, c < shown_count: blink_lo = c, blink_hi = shown_count, phase = 1 (visible), frame_cnt = 0, toggles = 0, go to BLINK.
- IDLE, c >= shown_count: shown_count = c.
- BLINK:
  - frame_cnt increments each frame_start.
  - When frame_cnt reaches BLINK_PERIOD-1: frame_cnt = 0, phase inverts, toggles increments.
  - When toggles reaches BLINK_TOGGLES: shown_count = blink_lo, go to IDLE.
- BLINK, further decrease (c < blink_lo): blink_lo = c, blink_hi unchanged, frame_cnt and toggles restart, phase = 1.
- BLINK, increase (c > blink_lo): blink cancelled, shown_count = c, go to IDLE in the same frame_start cycle.
- blink_active = (state == BLINK), registered.

Visibility, slot s = (x - ORIGIN_X) >> SLOT_SHIFT:
- IDLE: visible if s < shown_count.
- BLINK: visible if s < blink_lo, or if blink_lo <= s < blink_hi and phase = 1.

Pixel pipeline (latency 2 cycles from x/y to outputs):
- Stage 0 (combinational into the ROM address register): hit requires all of:
  - x >= ORIGIN_X
  - col = (x - ORIGIN_X)[SLOT_SHIFT-1:0] < 2**ICON_W_LOG2
  - ORIGIN_Y <= y < ORIGIN_Y + ICON_H
  - slot visible
- Stage 0 address:
  - r = y - ORIGIN_Y; row = FLIP_Y ? ICON_H-1-r : r.
  - addr = (row << ICON_W_LOG2) + col.
  - Address is forced to 0 when there is no hit. hit is registered alongside.
- Stage 1: synchronous ROM (1-cycle read) returns a 4-bit code.
- Stage 2 (registered):
  - code 0 is transparent: valid = 0, pixel = 0.
  - code 1..7 maps through the palette: valid = hit_d, pixel = palette[code] if hit_d else 0.
  - code 8..15 is reserved: treated as transparent.
- Palette decode is fully specified for every code (no latches).
- x, y arithmetic is 10-bit unsigned; no wrap past 1023 is required.

Boundaries:
- icon_count = 0: nothing drawn.
- icon_count > MAX_COUNT: clamps to MAX_COUNT.
- Count change without frame_start: ignored until the next pulse.
- frame_start while rst_n low: ignored.
- Reset mid-blink: returns to IDLE with shown_count = 0.

Decomposition:
- Package hud_pkg holds:
  - palette constants BLACK, WHITE, RED, GREY, BODY_YELLOW, ORANGE, DARK_GREY (codes 1..7);
  - state encoding IDLE/BLINK;
  - code width constant ICON_CODE_W = 4.
- One sub-module icon_rom: synchronous single-port ROM, addr width ICON_W_LOG2+clog2(ICON_H), 4-bit data, init file parameter.
- FSM and pixel pipeline stay in icon_row_show.

Test Plan:
- Static draw: reset, icon_count = 3, one frame_start; scan y = 460..475, x = 0..63. Expect valid only for x < 48; pixel matches palette[ROM] two cycles after each x/y; x = 48..63 gives valid = 0.
- Clamp: icon_count = 12 with MAX_COUNT = 8. Expect the last drawn slot to be 7 (x = 112..127) and x = 128 to be invalid.
- Blink: count 5 -> 3 at frame F. Expect slots 3-4 visible for frames F..F+7, invisible for F+8..F+15, and so on. After 6 toggles (frame F+48) they are gone; blink_active falls at the same frame_start.
- Nested decrease: 5 -> 3, then 1 at frame F+10. Expect slots 1-4 blinking with the counter restarted; final shown_count = 1.
- Cancel: 5 -> 3, then 4 at F+5. Expect blink_active = 0 immediately and slots 0-3 steady.
- Async reset mid-blink (rst_n low between clock edges). Expect all outputs 0 immediately; after release nothing is drawn until frame_start.

Source files
------------

// File: rtl/hud_pkg.sv
// hud_pkg: shared HUD overlay definitions.
//   - palette colours for sprite codes 1..7 (0 is transparent, 8..15 reserved)
//   - count FSM state encoding
//   - sprite code width
package hud_pkg;

  localparam int ICON_CODE_W = 4;

  localparam logic [23:0] BLACK       = 24'h000000;
  localparam logic [23:0] WHITE       = 24'hFFFFFF;
  localparam logic [23:0] RED         = 24'hFF0000;
  localparam logic [23:0] GREY        = 24'h808080;
  localparam logic [23:0] BODY_YELLOW = 24'hFFD800;
  localparam logic [23:0] ORANGE      = 24'hFF8000;
  localparam logic [23:0] DARK_GREY   = 24'h404040;

  typedef enum logic {
    IDLE  = 1'b0,
    BLINK = 1'b1
  } state_e;

  // Every code decodes; transparent and reserved codes give black so the
  // mux never sees stale colour.
  function automatic logic [23:0] palette(input logic [ICON_CODE_W-1:0] code);
    case (code)
      4'd1:    palette = BLACK;
      4'd2:    palette = WHITE;
      4'd3:    palette = RED;
      4'd4:    palette = GREY;
      4'd5:    palette = BODY_YELLOW;
      4'd6:    palette = ORANGE;
      4'd7:    palette = DARK_GREY;
      default: palette = 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/icon_rom.sv
// icon_rom: synchronous single-port sprite ROM, one-cycle read latency.
//   clk    : pixel clock
//   i_addr : {row, col} address, row in the upper bits
//   o_data : 4-bit sprite code, valid the cycle after i_addr
// Contents are a fixed diagonal test sprite, code = row ^ col (truncated to
// the code width), held as logic so the block carries no file dependency.
// The pattern exercises transparent (0), palette (1..7) and reserved
// (8..15) codes.
module icon_rom
  import hud_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int COL_W  = 4
) (
  input  logic                   clk,
  input  logic [ADDR_W-1:0]      i_addr,
  output logic [ICON_CODE_W-1:0] o_data
);

  logic [ICON_CODE_W-1:0] w_code;
  logic [ICON_CODE_W-1:0] r_data;

  assign w_code = ICON_CODE_W'(i_addr[COL_W-1:0]) ^ ICON_CODE_W'(i_addr >> COL_W);

  always_ff @(posedge clk) r_data <= w_code;

  assign o_data = r_data;

endmodule

// File: rtl/icon_row_show.sv
// icon_row_show: HUD icon-row renderer for the VGA overlay path.
//   clk, rst_n        : pixel clock, async active-low reset
//   frame_start       : one-cycle pulse per frame; the only time count state moves
//   current_pixel_x/y : scan position (10-bit)
//   icon_count        : requested icon count, clamped to MAX_COUNT
//   icon_pixel        : RGB888, 2 cycles after x/y
//   icon_pixel_valid  : pixel is opaque icon content
//   blink_active      : removed icons are blinking
module icon_row_show
  import hud_pkg::*;
#(
  parameter int ICON_W_LOG2   = 4,
  parameter int ICON_H        = 16,
  parameter int SLOT_SHIFT    = 4,
  parameter int MAX_COUNT     = 8,
  parameter int ORIGIN_X      = 0,
  parameter int ORIGIN_Y      = 460,
  parameter int FLIP_Y        = 1,
  parameter int BLINK_PERIOD  = 8,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [9:0]  current_pixel_x,
  input  logic [9:0]  current_pixel_y,
  input  logic [3:0]  icon_count,
  output logic [23:0] icon_pixel,
  output logic        icon_pixel_valid,
  output logic        blink_active
);

  localparam int ROW_W  = (ICON_H > 1) ? $clog2(ICON_H) : 1;
  localparam int ADDR_W = ICON_W_LOG2 + ROW_W;

  // ---------------- count FSM ----------------
  state_e     r_state, w_state_nx;
  logic [3:0] r_shown, w_shown_nx;
  logic [3:0] r_lo, w_lo_nx;
  logic [3:0] r_hi, w_hi_nx;
  logic       r_phase, w_phase_nx;
  logic [7:0] r_fcnt, w_fcnt_nx;
  logic [7:0] r_tog, w_tog_nx;
  logic [3:0] w_cnt;

  assign w_cnt = (icon_count > 4'(MAX_COUNT)) ? 4'(MAX_COUNT) : icon_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shown <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_phase <= 1'b1;
      r_fcnt  <= '0;
      r_tog   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_shown <= w_shown_nx;
      r_lo    <= w_lo_nx;
      r_hi    <= w_hi_nx;
      r_phase <= w_phase_nx;
      r_fcnt  <= w_fcnt_nx;
      r_tog   <= w_tog_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_shown_nx = r_shown;
    w_lo_nx    = r_lo;
    w_hi_nx    = r_hi;
    w_phase_nx = r_phase;
    w_fcnt_nx  = r_fcnt;
    w_tog_nx   = r_tog;
    if (frame_start) begin
      case (r_state)
        IDLE: begin
          if (w_cnt < r_shown) begin
            w_lo_nx    = w_cnt;
            w_hi_nx    = r_shown;
            w_phase_nx = 1'b1;
            w_fcnt_nx  = '0;
            w_tog_nx   = '0;
            w_state_nx = BLINK;
          end else begin
            w_shown_nx = w_cnt;
          end
        end
        BLINK: begin
          // A count change overrides the running blink: a further drop
          // restarts it with the wider range, a rise cancels it outright.
          if (w_cnt < r_lo) begin
            w_lo_nx    = w_cnt;
            w_phase_nx = 1'b1;
            w_fcnt_nx  = '0;
            w_tog_nx   = '0;
          end else if (w_cnt > r_lo) begin
            w_shown_nx = w_cnt;
            w_state_nx = IDLE;
          end else if (r_fcnt == 8'(BLINK_PERIOD - 1)) begin
            w_fcnt_nx  = '0;
            w_phase_nx = ~r_phase;
            w_tog_nx   = r_tog + 8'd1;
            if (r_tog == 8'(BLINK_TOGGLES - 1)) begin
              w_shown_nx = r_lo;
              w_state_nx = IDLE;
            end
          end else begin
            w_fcnt_nx = r_fcnt + 8'd1;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  assign blink_active = (r_state == BLINK);

  // ---------------- stage 0: hit test and ROM address ----------------
  logic [10:0]             w_dx, w_dy;
  logic                    w_x_ok, w_y_ok, w_col_ok, w_slot_ok, w_hit;
  logic [ICON_W_LOG2-1:0]  w_col;
  logic [ROW_W-1:0]        w_r, w_row;
  logic [9:0]              w_slot;
  logic [3:0]              w_vis_n;
  logic [ADDR_W-1:0]       w_addr;

  // 11-bit differences: the top bit flags a position left of / above origin.
  assign w_dx   = {1'b0, current_pixel_x} - 11'(ORIGIN_X);
  assign w_dy   = {1'b0, current_pixel_y} - 11'(ORIGIN_Y);
  assign w_x_ok = ~w_dx[10];
  assign w_y_ok = ~w_dy[10] && (w_dy[9:0] < 10'(ICON_H));
  assign w_col  = w_dx[ICON_W_LOG2-1:0];
  assign w_slot = 10'(w_dx[9:SLOT_SHIFT]);

  generate
    if (SLOT_SHIFT > ICON_W_LOG2) begin : g_gap
      assign w_col_ok = ~|w_dx[SLOT_SHIFT-1:ICON_W_LOG2];
    end else begin : g_nogap
      assign w_col_ok = 1'b1;
    end
  endgenerate

  // Visible slots always form a prefix: a blinking range shows as hi
  // during the on phase and lo during the off phase.
  assign w_vis_n   = (r_state == BLINK) ? (r_phase ? r_hi : r_lo) : r_shown;
  assign w_slot_ok = (w_slot < 10'(w_vis_n));
  assign w_hit     = w_x_ok && w_col_ok && w_y_ok && w_slot_ok;

  assign w_r   = w_dy[ROW_W-1:0];
  assign w_row = (FLIP_Y != 0) ? (ROW_W'(ICON_H - 1) - w_r) : w_r;
  assign w_addr = w_hit ? {w_row, w_col} : '0;

  // ---------------- stage 1: ROM read, hit travels alongside ----------------
  logic [ICON_CODE_W-1:0] w_code;
  logic                   r_hit_d;

  icon_rom #(
    .ADDR_W (ADDR_W),
    .COL_W  (ICON_W_LOG2)
  ) u_rom (
    .clk    (clk),
    .i_addr (w_addr),
    .o_data (w_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hit_d <= 1'b0;
    else        r_hit_d <= w_hit;
  end

  // ---------------- stage 2: palette and output register ----------------
  logic        w_opaque;
  logic        r_pix_vld;
  logic [23:0] r_pix;

  assign w_opaque = r_hit_d && (w_code != '0) && (w_code <= ICON_CODE_W'(7));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_vld <= 1'b0;
      r_pix     <= '0;
    end else begin
      r_pix_vld <= w_opaque;
      r_pix     <= w_opaque ? palette(w_code) : 24'h000000;
    end
  end

  assign icon_pixel       = r_pix;
  assign icon_pixel_valid = r_pix_vld;

endmodule

// File: tb/tb_icon_row_show.sv
// tb_icon_row_show: directed bench for icon_row_show with default parameters
// (16x16 icons, pitch 16, MAX_COUNT 8, origin (0,460), FLIP_Y, blink 8 x 6).
module tb_icon_row_show;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  px = '0, py = '0;
  logic [3:0]  cnt = '0;
  logic [23:0] pix;
  logic        pv, ba;

  int checks = 0;
  int errors = 0;

  icon_row_show dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_start      (frame_start),
    .current_pixel_x  (px),
    .current_pixel_y  (py),
    .icon_count       (cnt),
    .icon_pixel       (pix),
    .icon_pixel_valid (pv),
    .blink_active     (ba)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic        v;
    logic [23:0] p;
  } vec_t;

  function automatic logic [23:0] pal(int c);
    case (c)
      1: return 24'h000000;
      2: return 24'hFFFFFF;
      3: return 24'hFF0000;
      4: return 24'h808080;
      5: return 24'hFFD800;
      6: return 24'hFF8000;
      7: return 24'h404040;
      default: return 24'h000000;
    endcase
  endfunction

  // {valid, pixel} for a pixel with the leftmost nvis slots visible.
  // Sprite: code = row ^ col, ROM row 0 is the bottom screen row.
  function automatic logic [24:0] model(int x, int y, int nvis);
    int r, col, code;
    if (y < 460 || y > 475 || (x / 16) >= nvis) return '0;
    r    = y - 460;
    col  = x % 16;
    code = (15 - r) ^ col;
    if (code >= 1 && code <= 7) return {1'b1, pal(code)};
    return '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    cnt = '0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  // Hold one position for two edges and read the result.
  task automatic probe(input int x, input int y, output logic v, output logic [23:0] p);
    @(posedge clk); #1;
    px = 10'(x); py = 10'(y);
    @(posedge clk);
    @(posedge clk); #1;
    v = pv; p = pix;
  endtask

  // Slot s probe: (16s+14, 460) is code 1 (black, opaque) when visible.
  task automatic chk_slot(input string tag, input int s, input logic exp);
    logic v; logic [23:0] p;
    probe(16 * s + 14, 460, v, p);
    chk($sformatf("%s slot%0d", tag, s), 32'(v), 32'(exp));
  endtask

  // Streaming scan: one new position per cycle, output compared exactly
  // two cycles later.
  logic [24:0] q_exp[$];
  int          q_x[$], q_y[$];

  task automatic step(input int x, input int y, input int nvis);
    logic [24:0] e; int ex, ey;
    @(posedge clk); #1;
    if (q_exp.size() == 2) begin
      e = q_exp.pop_front(); ex = q_x.pop_front(); ey = q_y.pop_front();
      chk($sformatf("scan x=%0d y=%0d", ex, ey), 32'({pv, pix}), 32'(e));
    end
    px = 10'(x); py = 10'(y);
    q_exp.push_back(model(x, y, nvis)); q_x.push_back(x); q_y.push_back(y);
  endtask

  task automatic flush();
    step(1000, 0, 0);
    step(1000, 0, 0);
    q_exp.delete(); q_x.delete(); q_y.delete();
  endtask

  vec_t vecs[$];

  initial begin
    logic v; logic [23:0] p; logic vis;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 32'(pv), 32'(0));
    chk("reset pixel", 32'(pix), 32'(0));
    chk("reset blink", 32'(ba), 32'(0));
    @(negedge clk) rst_n = 1'b1;

    // ---- static draw, count 3 ----
    cnt = 4'd3;
    pulse();
    chk("static blink", 32'(ba), 32'(0));
    vecs = '{
      '{14, 460, 1'b1, 24'h000000}, '{13, 460, 1'b1, 24'hFFFFFF},
      '{12, 460, 1'b1, 24'hFF0000}, '{11, 460, 1'b1, 24'h808080},
      '{10, 460, 1'b1, 24'hFFD800}, '{ 9, 460, 1'b1, 24'hFF8000},
      '{ 8, 460, 1'b1, 24'h404040}, '{15, 460, 1'b0, 24'h000000},
      '{ 0, 460, 1'b0, 24'h000000}, '{ 0, 475, 1'b0, 24'h000000},
      '{ 1, 475, 1'b1, 24'h000000}, '{ 7, 475, 1'b1, 24'h404040},
      '{33, 475, 1'b1, 24'h000000}, '{49, 475, 1'b0, 24'h000000},
      '{ 1, 476, 1'b0, 24'h000000}, '{ 1, 459, 1'b0, 24'h000000},
      '{23, 460, 1'b0, 24'h000000}, '{31, 461, 1'b1, 24'h000000},
      '{46, 460, 1'b1, 24'h000000}, '{62, 460, 1'b0, 24'h000000}
    };
    foreach (vecs[i]) begin
      probe(vecs[i].x, vecs[i].y, v, p);
      chk($sformatf("vec%0d valid", i), 32'(v), 32'(vecs[i].v));
      chk($sformatf("vec%0d pixel", i), 32'(p), 32'(vecs[i].p));
    end

    for (int y = 459; y <= 476; y++)
      for (int x = 0; x < 64; x++) step(x, y, 3);
    flush();

    // ---- count change without frame_start is ignored ----
    cnt = 4'd8;
    chk_slot("nopulse", 5, 1'b0);
    chk_slot("nopulse", 2, 1'b1);

    // ---- clamp: 12 -> 8 ----
    cnt = 4'd12;
    pulse();
    for (int y = 460; y <= 462; y++)
      for (int x = 96; x < 144; x++) step(x, y, 8);
    flush();
    chk_slot("clamp", 7, 1'b1);
    chk_slot("clamp", 8, 1'b0);

    // ---- blink 5 -> 3 ----
    do_reset();
    cnt = 4'd5; pulse();
    cnt = 4'd3; pulse();
    for (int k = 0; k < 50; k++) begin
      vis = (k < 48) && (((k / 8) % 2) == 0);
      chk($sformatf("blink k=%0d active", k), 32'(ba), 32'(k < 48));
      chk_slot($sformatf("blink k=%0d", k), 3, vis);
      if (k % 8 == 0 || k == 47 || k == 49) begin
        chk_slot($sformatf("blink k=%0d", k), 4, vis);
        chk_slot($sformatf("blink k=%0d", k), 2, 1'b1);
      end
      pulse();
    end

    // ---- nested decrease: 5 -> 3, then 1 at F+10 ----
    do_reset();
    cnt = 4'd5; pulse();
    cnt = 4'd3; pulse();
    for (int k = 1; k < 10; k++) pulse();
    chk_slot("nest pre", 3, 1'b0);
    cnt = 4'd1; pulse();
    for (int m = 0; m <= 48; m++) begin
      vis = (m < 48) && (((m / 8) % 2) == 0);
      chk($sformatf("nest m=%0d active", m), 32'(ba), 32'(m < 48));
      chk_slot($sformatf("nest m=%0d", m), 1, vis);
      if (m % 8 == 0 || m == 48) begin
        chk_slot($sformatf("nest m=%0d", m), 4, vis);
        chk_slot($sformatf("nest m=%0d", m), 0, 1'b1);
      end
      if (m < 48) pulse();
    end

    // ---- cancel: 5 -> 3, then 4 at F+5 ----
    do_reset();
    cnt = 4'd5; pulse();
    cnt = 4'd3; pulse();
    for (int k = 1; k < 5; k++) pulse();
    chk("cancel pre active", 32'(ba), 32'(1));
    cnt = 4'd4; pulse();
    chk("cancel active", 32'(ba), 32'(0));
    for (int s = 0; s < 5; s++) chk_slot("cancel", s, s < 4);
    for (int k = 0; k < 10; k++) pulse();
    chk("cancel steady active", 32'(ba), 32'(0));
    chk_slot("cancel steady", 3, 1'b1);
    chk_slot("cancel steady", 4, 1'b0);

    // ---- async reset mid-blink ----
    do_reset();
    cnt = 4'd5; pulse();
    cnt = 4'd3; pulse();
    probe(14, 460, v, p);
    chk("arst pre valid", 32'(v), 32'(1));
    chk("arst pre active", 32'(ba), 32'(1));
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(pv), 32'(0));
    chk("arst pixel", 32'(pix), 32'(0));
    chk("arst active", 32'(ba), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("arst post valid", 32'(pv), 32'(0));
    chk_slot("arst post", 0, 1'b0);
    pulse();
    chk_slot("arst frame", 0, 1'b1);
    chk_slot("arst frame", 2, 1'b1);
    chk_slot("arst frame", 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
